uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1 asynchronous serial transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Bit period is set by parameter BAUD, in system clocks per bit.
- Used by the command/data sender blocks to stream ROM bytes and measurement bytes to a PC.
- Simple level-sensitive start / ready handshake.

Parameters:
- BAUD, 434, clocks per bit (434 = 115200 baud at 50 MHz). Legal range 2..2^24-1.

Ports:
- clk    input   1  system clock; all logic on rising edge.
- rstn   input   1  asynchronous, active-high reset. The name is kept for codebase compatibility; polarity is high.
- data   input   8  byte to transmit; sampled only at frame launch.
- start  input   1  transmit request, level-sensitive.
- ready  output  1  1 = idle and able to accept start; 0 = frame in progress.
- tx     output  1  serial line, idle high; registered output.

Behaviour:
- Reset (rstn=1, asynchronous):
  - state=IDLE, tx=1, ready=1.
  - Baud counter, bit counter and shift register cleared.
  - An in-flight frame is aborted immediately and the line returns to idle high.
- States:
  - IDLE: ready=1, tx=1.
  - TRANS: ready=0, tx driven from the shift register.
- Launch:
  - Condition: rising edge with state=IDLE and start=1.
  - Load the 10-bit shift register with {1'b1, data, 1'b0}.
  - Clear the baud counter and set the bit counter to 0.
  - state moves to TRANS.
  - From the next cycle: ready=0 and tx=0 (start bit).
- Bit timing:
  - The baud counter counts 0..BAUD-1.
  - At count BAUD-1, shift right by one (fill with 1), advance the bit counter, reset the counter.
  - tx follows the shift-register LSB, registered.
  - Every bit is exactly BAUD clocks.
- Bit order on tx: start(0), d0, d1, …, d7, stop(1).
- Completion:
  - At the end of the 10th bit period (stop bit), state moves to IDLE, ready=1, tx stays 1.
  - ready is low for exactly 10*BAUD cycles per frame.
- Back-to-back frames:
  - If start is still 1 when IDLE is re-entered, a new frame launches on the next edge.
  - Minimum gap between frames is the stop bit plus 1 idle clock.
  - Continuous start=1 produces repeated frames, each using data sampled at its launch.
- Input handling while busy:
  - start is ignored while state=TRANS; no queuing.
  - data changes during a frame do not affect the frame.
- No parity, no break generation, no framing options.
- Widths:
  - Baud counter: clog2(BAUD) bits.
  - Bit counter: 4 bits, counts 0..9.
  - No wrap or overflow is possible inside a frame.

Decomposition:
- Shared package uart_pkg:
  - Baud constants B115200=434, B57600=868, B38400=1302, B19200=2604, B9600=5208, B4800=10417, B2400=20833, B1200=41667, B600=83333, B300=166667 (50 MHz clock).
  - FSM state enum {IDLE, TRANS}.
- One natural sub-module: uart_baud_gen.
  - Parameter BAUD.
  - Inputs: clk, rstn, enable (clears when low).
  - Output: single-cycle tick every BAUD clocks while enabled.
- The FSM and shift register stay in uart_tx.

Test Plan:
- Reset: assert rstn mid-frame (BAUD=4, data=8'hA5, 7 cycles after launch) -> tx=1 and ready=1 asynchronously; no further transitions after release while start=0.
- Single frame: BAUD=4, data=8'h55, start pulsed 1 cycle in IDLE.
  - ready=0 from the next cycle for exactly 40 cycles.
  - tx sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1.
  - Then ready=1, tx=1.
- Bit order: data=8'h01, BAUD=2 -> tx bits 0,1,0,0,0,0,0,0,0,1 (LSB first); recovered byte equals 8'h01.
- Held start: start=1 continuously, data=8'h41 then 8'h42 changed mid-frame.
  - First frame carries 8'h41; second launches one cycle after ready rises and carries 8'h42.
  - Gap is BAUD+1 clocks of tx=1 between data bits.
- Busy ignore: pulse start while ready=0 (BAUD=4) -> no effect on the current frame; no extra frame queued; ready rises exactly 40 cycles after the first launch.
- Default BAUD=434: frame of 8'hFF -> start-bit low for exactly 434 cycles; ready low for exactly 4340 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: standard bit periods for a
// 50 MHz system clock and the transmitter FSM state type.
package uart_pkg;

    localparam int B115200 = 434;
    localparam int B57600  = 868;
    localparam int B38400  = 1302;
    localparam int B19200  = 2604;
    localparam int B9600   = 5208;
    localparam int B4800   = 10417;
    localparam int B2400   = 20833;
    localparam int B1200   = 41667;
    localparam int B600    = 83333;
    localparam int B300    = 166667;

    localparam int FRAME_BITS = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        TRANS = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level port of the UART transmitter plus its serial line and FSM state.
// Handshake: start is a level request; a frame launches on the rising edge
// where ready=1 and start=1, data is sampled only at that edge, and ready
// stays low for the whole frame while start is ignored.
interface uart_tx_if;
    import uart_pkg::*;

    logic [7:0] data;
    logic       start;
    logic       ready;
    logic       tx;
    tx_state_e  state;

    modport master (
        output data,
        output start,
        input  ready,
        input  tx,
        input  state
    );

    modport slave (
        input  data,
        input  start,
        output ready,
        output tx,
        output state
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD-1 while enabled and flags the last count
// with a single-cycle tick; held at zero while disabled.
module uart_baud_gen #(
    parameter int BAUD = 434
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, stop bit,
// each BAUD clocks long; tx is registered and idles high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD = 434
) (
    input  logic        clk,
    input  logic        rstn,
    uart_tx_if.slave    bus
);

    tx_state_e  state, state_next;
    logic [9:0] shreg, shreg_next;
    logic [3:0] bit_cnt, bit_cnt_next;
    logic       tx_q, tx_next;
    logic       tick;

    uart_baud_gen #(.BAUD(BAUD)) u_baud_gen (
        .clk    (clk),
        .rstn   (rstn),
        .enable (state == TRANS),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            tx_q    <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_next   = {1'b1, bus.data, 1'b0};
                    bit_cnt_next = '0;
                    state_next   = TRANS;
                end
            end
            TRANS: begin
                if (tick) begin
                    if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        shreg_next   = {1'b1, shreg[9:1]};
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Registering the next LSB makes the start bit appear the cycle after launch.
        tx_next = (state_next == TRANS) ? shreg_next[0] : 1'b1;
    end

    assign bus.ready = (state == IDLE);
    assign bus.tx    = tx_q;
    assign bus.state = state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (BAUD 4, 2, 434) checked every cycle
// against a frame-timeline model, plus directed frame decodes.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int NDUT = 3;
    localparam int BAUD_V [NDUT] = '{4, 2, 434};

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       start_v [NDUT];
    logic [7:0] data_v  [NDUT];
    logic       tx_v    [NDUT];
    logic       ready_v [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_if if_a ();
    uart_tx_if if_b ();
    uart_tx_if if_c ();

    uart_tx #(.BAUD(4))   dut_a (.clk(clk), .rstn(rstn), .bus(if_a.slave));
    uart_tx #(.BAUD(2))   dut_b (.clk(clk), .rstn(rstn), .bus(if_b.slave));
    uart_tx #(.BAUD(434)) dut_c (.clk(clk), .rstn(rstn), .bus(if_c.slave));

    assign if_a.start = start_v[0];
    assign if_a.data  = data_v[0];
    assign if_b.start = start_v[1];
    assign if_b.data  = data_v[1];
    assign if_c.start = start_v[2];
    assign if_c.data  = data_v[2];
    assign tx_v[0]    = if_a.tx;
    assign tx_v[1]    = if_b.tx;
    assign tx_v[2]    = if_c.tx;
    assign ready_v[0] = if_a.ready;
    assign ready_v[1] = if_b.ready;
    assign ready_v[2] = if_c.ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a 10-bit word; each bit lasts BAUD cycles; the
    // line is busy for 10*BAUD cycles and a launch needs one idle edge.
    int         rem   [NDUT] = '{0, 0, 0};
    int         pos   [NDUT] = '{0, 0, 0};
    logic [9:0] frame [NDUT];

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < NDUT; i++) begin
                rem[i] <= 0;
                pos[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                if (rem[i] > 0) begin
                    rem[i] <= rem[i] - 1;
                    pos[i] <= pos[i] + 1;
                end else if (start_v[i] === 1'b1) begin
                    frame[i] <= {1'b1, data_v[i], 1'b0};
                    rem[i]   <= FRAME_BITS * BAUD_V[i];
                    pos[i]   <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            logic exp_ready;
            logic exp_tx;
            exp_ready = (rem[i] == 0);
            exp_tx    = (rem[i] > 0) ? frame[i][pos[i] / BAUD_V[i]] : 1'b1;
            check($sformatf("ready_dut%0d", i), 32'(ready_v[i]), 32'(exp_ready));
            check($sformatf("tx_dut%0d", i), 32'(tx_v[i]), 32'(exp_tx));
        end
    end

    // Called in the first busy cycle; returns at the first negedge with ready=1.
    task automatic collect_frame(input int i, output logic [7:0] byte_out,
                                 output logic [9:0] bits, output int low,
                                 output int zlead, output int tones);
        logic q[$];
        int   b;
        b = BAUD_V[i];
        low = 0;
        for (int c = 0; c < 20 * b + 10; c++) begin
            if (ready_v[i] === 1'b1) break;
            q.push_back(tx_v[i]);
            low++;
            @(negedge clk);
        end
        bits = '0;
        if (q.size() >= FRAME_BITS * b) begin
            for (int j = 0; j < FRAME_BITS; j++) bits[j] = q[j * b + b / 2];
        end
        byte_out = bits[8:1];
        zlead = 0;
        while (zlead < q.size() && q[zlead] == 1'b0) zlead++;
        tones = 0;
        while (tones < q.size() && q[q.size() - 1 - tones] == 1'b1) tones++;
    endtask

    task automatic launch(input int i, input logic [7:0] d);
        @(negedge clk);
        start_v[i] = 1'b1;
        data_v[i]  = d;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    initial begin
        logic [7:0] by;
        logic [9:0] bits;
        int         low, zl, to, hi, bad;

        for (int i = 0; i < NDUT; i++) begin
            start_v[i] = 1'b0;
            data_v[i]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset_ready%0d", i), 32'(ready_v[i]), 32'd1);
            check($sformatf("reset_tx%0d", i), 32'(tx_v[i]), 32'd1);
        end

        // Single frame 0x55 at BAUD=4
        launch(0, 8'h55);
        collect_frame(0, by, bits, low, zl, to);
        check("f55_ready_low", 32'(low), 32'd40);
        check("f55_bits", 32'(bits), 32'b1010101010);
        check("f55_byte", 32'(by), 32'h55);
        check("f55_idle_tx", 32'(tx_v[0]), 32'd1);

        // Bit order 0x01 at BAUD=2
        launch(1, 8'h01);
        collect_frame(1, by, bits, low, zl, to);
        check("f01_bits", 32'(bits), 32'b1000000010);
        check("f01_byte", 32'(by), 32'h01);
        check("f01_ready_low", 32'(low), 32'd20);

        // Held start, data changed mid-frame
        @(negedge clk);
        start_v[0] = 1'b1;
        data_v[0]  = 8'h41;
        @(negedge clk);
        fork
            begin
                repeat (15) @(negedge clk);
                data_v[0] = 8'h42;
            end
        join_none
        collect_frame(0, by, bits, low, zl, to);
        check("held1_byte", 32'(by), 32'h41);
        check("held1_low", 32'(low), 32'd40);
        hi = 0;
        while (ready_v[0] === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        check("held_ready_gap", 32'(hi), 32'd1);
        check("held_tx_high_gap", 32'(to + hi), 32'd5);
        start_v[0] = 1'b0;
        collect_frame(0, by, bits, low, zl, to);
        check("held2_byte", 32'(by), 32'h42);
        check("held2_low", 32'(low), 32'd40);

        // Start pulsed while busy
        launch(0, 8'h3C);
        fork
            begin
                repeat (9) @(negedge clk);
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
            end
        join_none
        collect_frame(0, by, bits, low, zl, to);
        check("busy_byte", 32'(by), 32'h3C);
        check("busy_low", 32'(low), 32'd40);
        bad = 0;
        repeat (12) begin
            if (ready_v[0] !== 1'b1) bad++;
            @(negedge clk);
        end
        check("busy_no_queued", 32'(bad), 32'd0);

        // Asynchronous reset mid-frame
        launch(0, 8'hA5);
        repeat (6) @(negedge clk);
        #1 rstn = 1'b1;
        #1;
        check("rst_async_tx", 32'(tx_v[0]), 32'd1);
        check("rst_async_ready", 32'(ready_v[0]), 32'd1);
        check("rst_async_state", 32'(if_a.state), 32'(IDLE));
        @(negedge clk);
        rstn = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1) bad++;
        end
        check("rst_quiet_after", 32'(bad), 32'd0);

        // Default rate, 0xFF
        launch(2, 8'hFF);
        collect_frame(2, by, bits, low, zl, to);
        check("ff_start_low", 32'(zl), 32'd434);
        check("ff_ready_low", 32'(low), 32'd4340);
        check("ff_byte", 32'(by), 32'hFF);

        // Random traffic on the fast instances
        repeat (2000) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                data_v[i]  = 8'($urandom);
            end
        end
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (60) @(negedge clk);
        check("end_idle_a", 32'(ready_v[0]), 32'd1);
        check("end_idle_b", 32'(ready_v[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
